// File: rtl/vme_a16_slave_regport.sv
// VME A16/D16 slave front end: strobe synchroniser, window decode, register strobes,
// read-data drive and DTACK/BERR handshake.
`timescale 1ns/1ps
module vme_a16_slave_regport #(
   parameter logic [15:0] BASE_ADDR   = 16'h7C80,
   parameter int unsigned NREG        = 24,
   parameter logic [5:0]  AM_SUPER    = 6'h2D,
   parameter logic [5:0]  AM_USER     = 6'h29,
   parameter bit          USER_EN     = 1'b1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DTACK_DELAY = 2,
   localparam int unsigned IW         = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic               I_CLK_32M,
   input  logic               I_VME_SYSRESET,
   input  logic               I_VME_AS,
   input  logic               I_VME_DS0,
   input  logic               I_VME_DS1,
   input  logic               I_VME_WR,
   input  logic               I_VME_LWORD,
   input  logic [15:1]        I_VME_A,
   input  logic [5:0]         I_VME_AM,
   input  logic [15:0]        I_VME_D,
   output logic [15:0]        O_VME_D,
   output logic               O_VME_D_OE,
   output logic               O_VME_DTACK_D,
   output logic               O_VME_DTACK_EN,
   output logic               O_VME_BERR,
   output logic [IW-1:0]      O_REG_IDX,
   output logic [NREG-1:0]    O_REG_WR_STB,
   output logic [15:0]        O_REG_WDATA,
   output logic               O_REG_RD_STB,
   input  logic [NREG*16-1:0] I_REG_RDATA
);

   typedef enum logic [2:0] {
      StIdle, StDecode, StAccess, StAckWait, StAck, StErr, StWaitRel
   } state_e;

   localparam logic [3:0] CNT_INIT = (DTACK_DELAY > 0) ? 4'(DTACK_DELAY - 1) : 4'd0;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] as_sync, ds0_sync, ds1_sync, wr_sync;
   logic sas, sds0, sds1, swr, sel, ds_rel;

   logic [15:1]     addr_q;
   logic [5:0]      am_q;
   logic            lword_q;
   logic            rnw_q;
   logic [15:0]     data_q;
   logic [3:0]      cnt_q;
   logic [IW-1:0]   idx;
   logic            in_win, am_ok, idx_bad;
   logic [NREG-1:0] onehot;
   logic [15:0]     rdata_sel;

   logic [15:0]     vme_d_q, wdata_q;
   logic [NREG-1:0] wr_stb_q;
   logic            rd_stb_q, oe_q, dtack_q, berr_q;

   // Strobes are active low; synchronisers reset to the idle (high) level.
   always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
      if (I_VME_SYSRESET) begin
         as_sync  <= '1;
         ds0_sync <= '1;
         ds1_sync <= '1;
         wr_sync  <= '1;
      end else begin
         as_sync  <= {as_sync[SYNC_STAGES-2:0], I_VME_AS};
         ds0_sync <= {ds0_sync[SYNC_STAGES-2:0], I_VME_DS0};
         ds1_sync <= {ds1_sync[SYNC_STAGES-2:0], I_VME_DS1};
         wr_sync  <= {wr_sync[SYNC_STAGES-2:0], I_VME_WR};
      end
   end

   assign sas    = as_sync[SYNC_STAGES-1];
   assign sds0   = ds0_sync[SYNC_STAGES-1];
   assign sds1   = ds1_sync[SYNC_STAGES-1];
   assign swr    = wr_sync[SYNC_STAGES-1];
   assign sel    = !sas && !sds0 && !sds1;
   assign ds_rel = sds0 && sds1;

   assign idx     = addr_q[IW:1];
   assign am_ok   = (am_q == AM_SUPER) || (USER_EN && (am_q == AM_USER));
   assign in_win  = (addr_q[15:IW+1] == BASE_ADDR[15:IW+1]) && am_ok;
   assign idx_bad = {{(32-IW){1'b0}}, idx} >= NREG;

   always_comb begin
      onehot    = '0;
      rdata_sel = '0;
      for (int unsigned k = 0; k < NREG; k++) begin
         if (idx == IW'(k)) begin
            onehot[k] = 1'b1;
            rdata_sel = I_REG_RDATA[16*k +: 16];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (sel) state_d = StDecode;
         StDecode: begin
            if (!in_win)                   state_d = StWaitRel;
            else if (idx_bad || !lword_q)  state_d = StErr;
            else                           state_d = StAccess;
         end
         // An early DS release skips the remaining delay; ACK then lasts one cycle.
         StAccess:  state_d = (DTACK_DELAY == 0 || ds_rel) ? StAck : StAckWait;
         StAckWait: if (cnt_q == 4'd0 || ds_rel) state_d = StAck;
         StAck:     if (ds_rel) state_d = StWaitRel;
         StErr:     if (ds_rel) state_d = StWaitRel;
         StWaitRel: if (sas) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
      if (I_VME_SYSRESET) begin
         state_q <= StIdle;
         addr_q  <= '0;
         am_q    <= '0;
         lword_q <= 1'b1;
         rnw_q   <= 1'b1;
         data_q  <= '0;
         cnt_q   <= CNT_INIT;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && sel) begin
            addr_q  <= I_VME_A;
            am_q    <= I_VME_AM;
            lword_q <= I_VME_LWORD;
            rnw_q   <= swr;
            data_q  <= I_VME_D;
         end
         if (state_q != StAckWait)  cnt_q <= CNT_INIT;
         else if (cnt_q != 4'd0)    cnt_q <= cnt_q - 4'd1;
      end
   end

   // Bus-side outputs are registered from the next state so they change with it.
   always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
      if (I_VME_SYSRESET) begin
         vme_d_q  <= '0;
         wdata_q  <= '0;
         wr_stb_q <= '0;
         rd_stb_q <= 1'b0;
         oe_q     <= 1'b0;
         dtack_q  <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         wr_stb_q <= (state_d == StAccess && !rnw_q) ? onehot : '0;
         rd_stb_q <= (state_d == StAccess) && rnw_q;
         if (state_d == StAccess) begin
            if (rnw_q) vme_d_q <= rdata_sel;
            else       wdata_q <= data_q;
         end
         oe_q    <= rnw_q && (state_d == StAckWait || state_d == StAck);
         dtack_q <= (state_d == StAck);
         berr_q  <= (state_d == StErr);
      end
   end

   assign O_VME_D        = vme_d_q;
   assign O_VME_D_OE     = oe_q;
   assign O_VME_DTACK_D  = !dtack_q;
   assign O_VME_DTACK_EN = dtack_q;
   assign O_VME_BERR     = berr_q;
   assign O_REG_IDX      = idx;
   assign O_REG_WR_STB   = wr_stb_q;
   assign O_REG_WDATA    = wdata_q;
   assign O_REG_RD_STB   = rd_stb_q;

endmodule

// File: tb/tb_vme_a16_slave_regport.sv
// Directed bench for vme_a16_slave_regport: timing, strobes, BERR, decode misses, reset, USER_EN=0.
`timescale 1ns/1ps
module tb_vme_a16_slave_regport;
   localparam int NREG = 24;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #15.625 clk = ~clk;

   logic        as_n = 1'b1, ds0_n = 1'b1, ds1_n = 1'b1, wr_n = 1'b1, lword_n = 1'b1;
   logic [15:1] a = '0;
   logic [5:0]  am = '0;
   logic [15:0] d_in = '0;
   logic [NREG*16-1:0] rdata;

   logic [15:0]     vme_d, wdata, vme_d_2, wdata_2;
   logic            oe, dtack_d, dtack_en, berr, rd_stb;
   logic            oe_2, dtack_d_2, dtack_en_2, berr_2, rd_stb_2;
   logic [4:0]      reg_idx, reg_idx_2;
   logic [NREG-1:0] wr_stb, wr_stb_2;

   vme_a16_slave_regport u_dut (
      .I_CLK_32M(clk), .I_VME_SYSRESET(rst), .I_VME_AS(as_n), .I_VME_DS0(ds0_n),
      .I_VME_DS1(ds1_n), .I_VME_WR(wr_n), .I_VME_LWORD(lword_n), .I_VME_A(a), .I_VME_AM(am),
      .I_VME_D(d_in), .O_VME_D(vme_d), .O_VME_D_OE(oe), .O_VME_DTACK_D(dtack_d),
      .O_VME_DTACK_EN(dtack_en), .O_VME_BERR(berr), .O_REG_IDX(reg_idx),
      .O_REG_WR_STB(wr_stb), .O_REG_WDATA(wdata), .O_REG_RD_STB(rd_stb), .I_REG_RDATA(rdata)
   );

   vme_a16_slave_regport #(.USER_EN(1'b0)) u_dut_nouser (
      .I_CLK_32M(clk), .I_VME_SYSRESET(rst), .I_VME_AS(as_n), .I_VME_DS0(ds0_n),
      .I_VME_DS1(ds1_n), .I_VME_WR(wr_n), .I_VME_LWORD(lword_n), .I_VME_A(a), .I_VME_AM(am),
      .I_VME_D(d_in), .O_VME_D(vme_d_2), .O_VME_D_OE(oe_2), .O_VME_DTACK_D(dtack_d_2),
      .O_VME_DTACK_EN(dtack_en_2), .O_VME_BERR(berr_2), .O_REG_IDX(reg_idx_2),
      .O_REG_WR_STB(wr_stb_2), .O_REG_WDATA(wdata_2), .O_REG_RD_STB(rd_stb_2),
      .I_REG_RDATA(rdata)
   );

   int checks = 0;
   int errors = 0;

   int              wr_cnt, rd_cnt, oe_early, u2_act;
   logic [NREG-1:0] wr_last;
   logic [15:0]     wdata_last;

   always @(negedge clk) begin
      if (|wr_stb) begin
         wr_cnt++;
         wr_last    = wr_stb;
         wdata_last = wdata;
      end
      if (rd_stb) rd_cnt++;
      if (oe && !dtack_en) oe_early++;
      if (dtack_en_2 || berr_2 || oe_2 || rd_stb_2 || (|wr_stb_2)) u2_act++;
   end

   task automatic start(input logic [15:0] addr, input logic [5:0] amod, input logic write,
                        input logic [15:0] data);
      @(negedge clk);
      wr_cnt = 0; rd_cnt = 0; oe_early = 0; u2_act = 0; wr_last = '0; wdata_last = '0;
      a = addr[15:1]; am = amod; wr_n = ~write; d_in = data;
      as_n = 1'b0; ds0_n = 1'b0; ds1_n = 1'b0;
   endtask

   // Edge number (1 = first edge sampling the strobes) at which DTACK or BERR appears.
   task automatic wait_resp(output int n);
      n = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if ((dtack_en && !dtack_d) || berr) begin
            n = e;
            break;
         end
      end
   endtask

   task automatic release_ds(output int n, output int split);
      @(negedge clk);
      ds0_n = 1'b1; ds1_n = 1'b1;
      n = -1; split = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (oe != dtack_en || dtack_d == dtack_en) split++;
         if (!dtack_en && !berr && !oe) begin
            n = e;
            break;
         end
      end
   endtask

   task automatic end_cycle();
      @(negedge clk);
      as_n = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #2;
      checks++; if (vme_d !== 16'h0) begin errors++; $display("FAIL rst_vme_d: got %h want 0000", vme_d); end
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", oe); end
      checks++; if (dtack_d !== 1'b1) begin errors++; $display("FAIL rst_dtack_d: got %b want 1", dtack_d); end
      checks++; if (dtack_en !== 1'b0) begin errors++; $display("FAIL rst_dtack_en: got %b want 0", dtack_en); end
      checks++; if (berr !== 1'b0) begin errors++; $display("FAIL rst_berr: got %b want 0", berr); end
      checks++; if (wr_stb !== '0) begin errors++; $display("FAIL rst_wr_stb: got %h want 0", wr_stb); end
      checks++; if (rd_stb !== 1'b0) begin errors++; $display("FAIL rst_rd_stb: got %b want 0", rd_stb); end
      checks++; if (reg_idx !== 5'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", reg_idx); end
      checks++; if (wdata !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0000", wdata); end
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write();
      int n, split;
      start(16'h7C88, 6'h2D, 1'b1, 16'h1234);
      wait_resp(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL wr_latency: got %0d want 7", n); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL wr_stb_cycles: got %0d want 1", wr_cnt); end
      checks++; if (wr_last !== 24'h000010) begin errors++; $display("FAIL wr_stb_vec: got %h want 000010", wr_last); end
      checks++; if (wdata_last !== 16'h1234) begin errors++; $display("FAIL wr_wdata: got %h want 1234", wdata_last); end
      checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL wr_no_rd: got %0d want 0", rd_cnt); end
      checks++; if (reg_idx !== 5'd4) begin errors++; $display("FAIL wr_idx: got %0d want 4", reg_idx); end
      release_ds(n, split);
      checks++; if (n !== 3) begin errors++; $display("FAIL wr_release: got %0d want 3", n); end
      end_cycle();
   endtask

   task automatic test_read();
      int n, split;
      start(16'h7CA4, 6'h29, 1'b0, 16'h0);
      wait_resp(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL rd_latency: got %0d want 7", n); end
      checks++; if (vme_d !== 16'hA800) begin errors++; $display("FAIL rd_data: got %h want a800", vme_d); end
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rd_oe_at_ack: got %b want 1", oe); end
      checks++; if (oe_early !== 2) begin errors++; $display("FAIL rd_oe_before_ack: got %0d want 2", oe_early); end
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL rd_stb_cycles: got %0d want 1", rd_cnt); end
      checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rd_no_wr: got %0d want 0", wr_cnt); end
      release_ds(n, split);
      checks++; if (n !== 3) begin errors++; $display("FAIL rd_release: got %0d want 3", n); end
      checks++; if (split !== 0) begin errors++; $display("FAIL rd_oe_dtack_together: got %0d want 0", split); end
      end_cycle();
   endtask

   task automatic test_berr();
      int n, split;
      start(16'h7CB0, 6'h2D, 1'b0, 16'h0);
      wait_resp(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL berr_latency: got %0d want 4", n); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (berr !== 1'b1) begin errors++; $display("FAIL berr_held: got %b want 1", berr); end
      checks++; if (dtack_en !== 1'b0) begin errors++; $display("FAIL berr_no_dtack: got %b want 0", dtack_en); end
      checks++; if (rd_cnt + wr_cnt !== 0) begin errors++; $display("FAIL berr_no_stb: got %0d want 0", rd_cnt + wr_cnt); end
      release_ds(n, split);
      checks++; if (n !== 3) begin errors++; $display("FAIL berr_release: got %0d want 3", n); end
      end_cycle();
   endtask

   task automatic test_no_decode();
      int n, split, act;
      logic [15:0] addrs [2];
      logic [5:0]  ams [2];
      addrs[0] = 16'h1000; ams[0] = 6'h2D;
      addrs[1] = 16'h7C88; ams[1] = 6'h39;
      for (int i = 0; i < 2; i++) begin
         start(addrs[i], ams[i], 1'b1, 16'hFFFF);
         act = 0;
         repeat (20) begin
            @(posedge clk); #1;
            if (dtack_en || !dtack_d || berr || oe || rd_stb || (|wr_stb)) act++;
         end
         checks++; if (act !== 0) begin errors++; $display("FAIL nodec_quiet_%0d: got %0d want 0", i, act); end
         release_ds(n, split);
         end_cycle();
      end
      start(16'h7C82, 6'h2D, 1'b1, 16'h0042);
      wait_resp(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL nodec_back_idle: got %0d want 7", n); end
      checks++; if (wr_last !== 24'h000002) begin errors++; $display("FAIL nodec_next_stb: got %h want 000002", wr_last); end
      release_ds(n, split);
      end_cycle();
   endtask

   task automatic test_reset_in_ack();
      int n, split;
      start(16'h7CA4, 6'h2D, 1'b0, 16'h0);
      wait_resp(n);
      @(negedge clk);
      rst = 1'b1;
      #2;
      checks++; if (dtack_en !== 1'b0) begin errors++; $display("FAIL rsta_dtack_en: got %b want 0", dtack_en); end
      checks++; if (dtack_d !== 1'b1) begin errors++; $display("FAIL rsta_dtack_d: got %b want 1", dtack_d); end
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rsta_oe: got %b want 0", oe); end
      as_n = 1'b1; ds0_n = 1'b1; ds1_n = 1'b1;
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      start(16'h7C9E, 6'h2D, 1'b1, 16'h5A5A);
      wait_resp(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL rsta_next_latency: got %0d want 7", n); end
      checks++; if (wr_last !== 24'h008000) begin errors++; $display("FAIL rsta_next_stb: got %h want 008000", wr_last); end
      checks++; if (wdata_last !== 16'h5A5A) begin errors++; $display("FAIL rsta_next_wdata: got %h want 5a5a", wdata_last); end
      release_ds(n, split);
      end_cycle();
   endtask

   task automatic test_long_hold();
      int n, split, drop;
      start(16'h7C90, 6'h2D, 1'b1, 16'hBEEF);
      wait_resp(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL hold_latency: got %0d want 7", n); end
      drop = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (!(dtack_en && !dtack_d)) drop++;
      end
      checks++; if (drop !== 0) begin errors++; $display("FAIL hold_dtack: got %0d drops want 0", drop); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL hold_one_stb: got %0d want 1", wr_cnt); end
      checks++; if (wr_last !== 24'h000100) begin errors++; $display("FAIL hold_stb_vec: got %h want 000100", wr_last); end
      release_ds(n, split);
      checks++; if (n !== 3) begin errors++; $display("FAIL hold_release: got %0d want 3", n); end
      end_cycle();
   endtask

   task automatic test_user_disabled();
      int n, split;
      start(16'h7C88, 6'h29, 1'b1, 16'h1111);
      repeat (20) @(posedge clk);
      #1;
      checks++; if (u2_act !== 0) begin errors++; $display("FAIL nouser_quiet: got %0d want 0", u2_act); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL user_en_accepts: got %0d want 1", wr_cnt); end
      release_ds(n, split);
      end_cycle();
   endtask

   initial begin
      for (int k = 0; k < NREG; k++) rdata[16*k +: 16] = 16'h0101 * k[15:0];
      rdata[18*16 +: 16] = 16'hA800;
      test_reset();
      test_write();
      test_read();
      test_berr();
      test_no_decode();
      test_reset_in_ack();
      test_long_hold();
      test_user_disabled();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
